result_display: RTL and testbench

Downstream consumer of the 32-bit array-readout stage. Accepts one 32-bit result word per cycle into a small FIFO and, while `sig_display` is high, streams buffered words out as 4-bit hex digits, MSB nibble first, over a valid/ready handshake. Overflow is counted, not back-pressured: the upstream stage has no stall input.

---
 rtl/display_pkg.sv | 11 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/result_display.sv | 100 ++++++++++
 tb/tb_result_display.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the result display path.
package display_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head word is readable in the same cycle it is popped.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              full_reg;
  logic              empty_reg;

  // Contents are not cleared on reset; the pointers alone discard them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/result_display.sv
// Buffers result words and streams them out as hex digits, MSB nibble first.
module result_display
  import display_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               sig_display,
  input  logic               disp_ready,
  output logic [DIGIT_W-1:0] disp_digit,
  output logic               disp_valid,
  output logic               disp_last,
  output logic               fifo_full,
  output logic [7:0]         drop_cnt
);

  localparam int NDIG  = DATA_W / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        drop_cnt_reg;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full_w;
  logic              fifo_empty;
  logic              word_done;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign word_done = (state_reg == ST_SHIFT) && disp_ready && (idx_reg == '0);
  assign pop       = sig_display && !fifo_empty && ((state_reg == ST_IDLE) || word_done);
  assign push      = in_valid && (!fifo_full_w || pop);
  assign drop      = in_valid && !push;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      idx_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (drop && (drop_cnt_reg != DROP_MAX)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            shreg_reg <= fifo_rdata;
            idx_reg   <= IDX_W'(NDIG - 1);
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (disp_ready) begin
            if (idx_reg != '0) begin
              shreg_reg <= shreg_reg << DIGIT_W;
              idx_reg   <= idx_reg - IDX_W'(1);
            end else if (pop) begin
              shreg_reg <= fifo_rdata;
              idx_reg   <= IDX_W'(NDIG - 1);
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign disp_valid = (state_reg == ST_SHIFT);
  assign disp_last  = disp_valid && (idx_reg == '0);
  assign disp_digit = shreg_reg[DATA_W-1 -: DIGIT_W];
  assign fifo_full  = fifo_full_w;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_result_display.sv
// Directed stimulus with a digit scoreboard drained by an independent monitor.
module tb_result_display;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int DIGIT_W = 4;
  localparam int NDIG    = DATA_W / DIGIT_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_valid = 1'b0;
  logic               sig_display = 1'b0;
  logic               disp_ready = 1'b1;
  logic [DIGIT_W-1:0] disp_digit;
  logic               disp_valid;
  logic               disp_last;
  logic               fifo_full;
  logic [7:0]         drop_cnt;

  typedef struct packed {
    logic [3:0] d;
    logic       last;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc;
  logic       hold_pending = 1'b0;
  logic [3:0] hold_digit = '0;

  result_display #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .DIGIT_W (DIGIT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sig_display (sig_display),
    .disp_ready  (disp_ready),
    .disp_digit  (disp_digit),
    .disp_valid  (disp_valid),
    .disp_last   (disp_last),
    .fifo_full   (fifo_full),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", int'(disp_valid), 1);
        check("hold_digit", int'(disp_digit), int'(hold_digit));
      end
      if (disp_valid && disp_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_digit: got 0x%0h, none expected", disp_digit);
        end else begin
          mon_e = sb_q.pop_front();
          check("digit", int'(disp_digit), int'(mon_e.d));
          check("last", int'(disp_last), int'(mon_e.last));
        end
      end else if (!disp_valid) begin
        check("last_when_idle", int'(disp_last), 0);
      end
      hold_pending = disp_valid && !disp_ready;
      hold_digit   = disp_digit;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_t e;
    for (int i = NDIG - 1; i >= 0; i--) begin
      e.d    = w[i*4 +: 4];
      e.last = (i == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    in_valid = 1'b1;
    in_data  = w;
    if (accepted) expect_word(w);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts samples with disp_valid high until it falls again.
  task automatic run_idle(output int n);
    bit seen = 0;
    n = 0;
    for (int b = 0; b <= 2000; b++) begin
      if (disp_valid) begin
        n++;
        seen = 1;
      end else if (seen) begin
        break;
      end
      if (b == 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL run_idle_timeout: got no idle within 2000 cycles, required idle");
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_cond(input bit want_last, input logic [3:0] d);
    for (int b = 0; b <= 500; b++) begin
      if (disp_valid && (want_last ? disp_last : (disp_digit == d))) break;
      if (b == 500) begin
        n_vec++;
        n_err++;
        $display("FAIL wait_timeout: got no digit 0x%0h / last=%0d, required one", d, want_last);
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(disp_valid), 0);
    check("rst_last", int'(disp_last), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_digit", int'(disp_digit), 0);
    check("rst_drop", int'(drop_cnt), 0);
    reset = 1'b0;
    tick();

    // Single word, full throughput
    sig_display = 1'b1;
    disp_ready  = 1'b1;
    push_word(32'h12345678, 1);
    check("lat_after_push", int'(disp_valid), 0);
    tick();
    check("lat_first_valid", int'(disp_valid), 1);
    check("lat_first_digit", int'(disp_digit), 1);
    run_idle(cyc);
    check("single_cycles", cyc, 8);
    check("single_idle", int'(disp_valid), 0);

    // Backpressure on digit 3
    push_word(32'h12345678, 1);
    wait_cond(0, 4'h3);
    disp_ready = 1'b0;
    repeat (3) tick();
    check("bp_digit", int'(disp_digit), 3);
    disp_ready = 1'b1;
    run_idle(cyc);
    check("bp_cycles", cyc, 6);

    // Overflow with display disabled
    sig_display = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_word(32'hA0 + 32'(i), i < 4);
      if (i == 2) check("not_full_after_3", int'(fifo_full), 0);
      if (i == 3) check("full_after_4", int'(fifo_full), 1);
    end
    check("overflow_drop", int'(drop_cnt), 2);

    // Saturation
    repeat (300) push_word(32'hFF, 0);
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_full", int'(fifo_full), 1);

    sig_display = 1'b1;
    run_idle(cyc);
    check("overflow_cycles", cyc, 32);
    check("overflow_drained", int'(fifo_full), 0);

    // Push while full on the reload edge
    sig_display = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i), 1);
    check("simul_pre_full", int'(fifo_full), 1);
    sig_display = 1'b1;
    tick();
    push_word(32'hC0, 1);
    check("simul_refill_full", int'(fifo_full), 1);
    wait_cond(1, 4'h0);
    push_word(32'hBEEF, 1);
    check("simul_full_kept", int'(fifo_full), 1);
    check("simul_drop_kept", int'(drop_cnt), 255);
    run_idle(cyc);
    check("simul_cycles", cyc, 40);

    // Reset during digit 5
    push_word(32'h12345678, 1);
    push_word(32'h9ABCDEF0, 1);
    wait_cond(0, 4'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("midrst_valid", int'(disp_valid), 0);
    check("midrst_full", int'(fifo_full), 0);
    check("midrst_drop", int'(drop_cnt), 0);
    repeat (3) tick();
    check("midrst_empty", int'(disp_valid), 0);

    // Display disabled at digit 2: word completes, next word is retained
    push_word(32'h0F1E2D3C, 1);
    push_word(32'h4B5A6978, 0);
    tick();
    sig_display = 1'b0;
    check("gate_digit2", int'(disp_digit), 'hF);
    run_idle(cyc);
    check("gate_cycles", cyc, 7);
    repeat (3) tick();
    check("gate_held_idle", int'(disp_valid), 0);
    expect_word(32'h4B5A6978);
    sig_display = 1'b1;
    run_idle(cyc);
    check("gate_retained_cycles", cyc, 8);

    tick();
    check("leftover_expected", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
